decay_interval_timer: RTL and testbench

Consumes the one-cycle coincidence pulse stream and turns event pairs into muon-decay interval measurements. The first pulse is the muon stop; it arms a cycle counter. A later pulse is the decay electron; it captures the elapsed cycle count. Results leave on a valid/ready interface toward the histogram/readout logic, with timeout and missed-event bookkeeping.

---
 rtl/decay_interval_timer_pkg.sv | 15 +
 rtl/decay_interval_timer.sv | 122 ++++++++++++
 tb/tb_decay_interval_timer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/decay_interval_timer_pkg.sv
// Shared definitions for the muon-decay interval timer and the histogram logic that consumes its results.
package decay_interval_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HOLD  = 2'd2
   } dit_state_e;

   localparam int DIT_COUNT_W   = 16;
   localparam int DIT_WINDOW    = 20000;
   localparam int DIT_DEAD_TIME = 4;
   localparam int DIT_MISS_W    = 8;

endpackage

// File: rtl/decay_interval_timer.sv
// Turns start/stop coincidence pulse pairs into interval measurements on a valid/ready port,
// with a timeout flag and a saturating missed-event counter.
module decay_interval_timer
   import decay_interval_timer_pkg::*;
#(
   parameter int COUNT_W   = DIT_COUNT_W,
   parameter int WINDOW    = DIT_WINDOW,
   parameter int DEAD_TIME = DIT_DEAD_TIME,
   parameter int MISS_W    = DIT_MISS_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               event_pulse,
   output logic [COUNT_W-1:0] interval,
   output logic               interval_valid,
   input  logic               interval_ready,
   output logic               timeout_pulse,
   output logic               busy,
   output logic [MISS_W-1:0]  missed_count
);

   localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
   localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] DEAD_C   = COUNT_W'(DEAD_TIME);
   localparam logic [COUNT_W-1:0] WIN_LAST = COUNT_W'(WINDOW - 1);
   localparam logic [MISS_W-1:0]  MISS_MAX = {MISS_W{1'b1}};
   localparam logic [MISS_W-1:0]  MISS_ONE = MISS_W'(1);

   dit_state_e         state_q, state_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [COUNT_W-1:0] interval_q, interval_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic               busy_q, busy_d;
   logic [MISS_W-1:0]  missed_q, missed_d;
   logic               handshake_s;

   // Next-state, counter, capture and bookkeeping.
   // A start loads 1 so the counter always equals cycles elapsed since the start cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      interval_d  = interval_q;
      timeout_d   = 1'b0;
      missed_d    = missed_q;
      handshake_s = valid_q & interval_ready;

      case (state_q)
         ST_IDLE: begin
            if (event_pulse) begin
               state_d = ST_ARMED;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         ST_ARMED: begin
            // An accepted stop takes priority over the timeout in the same cycle.
            if (event_pulse && (cnt_q >= DEAD_C)) begin
               state_d    = ST_HOLD;
               interval_d = cnt_q;
               cnt_d      = CNT_ZERO;
            end else if (cnt_q == WIN_LAST) begin
               state_d    = ST_IDLE;
               timeout_d  = 1'b1;
               cnt_d      = CNT_ZERO;
            end else begin
               cnt_d      = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (handshake_s) begin
               if (event_pulse) begin
                  state_d = ST_ARMED;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (event_pulse && (missed_q != MISS_MAX)) begin
               missed_d = missed_q + MISS_ONE;
            end else begin
               missed_d = missed_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      valid_d = (state_d == ST_HOLD);
      busy_d  = (state_d != ST_IDLE);
   end

   // State, counter, capture register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         interval_q <= CNT_ZERO;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
         missed_q   <= {MISS_W{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         interval_q <= interval_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
         missed_q   <= missed_d;
      end
   end

   assign interval       = interval_q;
   assign interval_valid = valid_q;
   assign timeout_pulse  = timeout_q;
   assign busy           = busy_q;
   assign missed_count   = missed_q;

endmodule

// File: tb/tb_decay_interval_timer.sv
// Directed self-checking bench for decay_interval_timer with default parameters.
module tb_decay_interval_timer;

   logic        clk;
   logic        rst_n;
   logic        event_pulse;
   logic [15:0] interval;
   logic        interval_valid;
   logic        interval_ready;
   logic        timeout_pulse;
   logic        busy;
   logic [7:0]  missed_count;

   int checks;
   int errors;

   decay_interval_timer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .event_pulse    (event_pulse),
      .interval       (interval),
      .interval_valid (interval_valid),
      .interval_ready (interval_ready),
      .timeout_pulse  (timeout_pulse),
      .busy           (busy),
      .missed_count   (missed_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      event_pulse = 1'b1;
      tick();
      event_pulse = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; event_pulse = 1'b0; interval_ready = 1'b0;
      repeat (3) tick();
      checks++; if (interval !== 16'd0) begin errors++; $display("FAIL reset_interval got %0d exp 0", interval); end
      checks++; if (interval_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", interval_valid); end
      checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_pulse); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL reset_missed got %0d exp 0", missed_count); end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      interval_ready = 1'b1;
      pulse();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b exp 1", busy); end
      repeat (99) tick();
      checks++; if (interval_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b exp 0", interval_valid); end
      pulse();
      checks++; if (interval_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", interval_valid); end
      checks++; if (interval !== 16'd100) begin errors++; $display("FAIL basic_interval got %0d exp 100", interval); end
      tick();
      checks++; if (interval_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got %b exp 0", interval_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b exp 0", busy); end
   endtask

   task automatic test_dead_time();
      interval_ready = 1'b1;
      pulse();
      tick();
      pulse();
      repeat (47) tick();
      checks++; if (interval_valid !== 1'b0) begin errors++; $display("FAIL dead_valid_early got %b exp 0", interval_valid); end
      pulse();
      checks++; if (interval !== 16'd50) begin errors++; $display("FAIL dead_interval got %0d exp 50", interval); end
      checks++; if (interval_valid !== 1'b1) begin errors++; $display("FAIL dead_valid got %b exp 1", interval_valid); end
      checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL dead_missed got %0d exp 0", missed_count); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dead_busy_fall got %b exp 0", busy); end
   endtask

   task automatic test_timeout();
      logic seen_valid;
      seen_valid = 1'b0;
      interval_ready = 1'b1;
      pulse();
      for (int i = 0; i < 19998; i++) begin
         if (interval_valid === 1'b1) seen_valid = 1'b1;
         tick();
      end
      checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", timeout_pulse); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_before got %b exp 1", busy); end
      tick();
      checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse got %b exp 1", timeout_pulse); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b exp 0", busy); end
      if (interval_valid === 1'b1) seen_valid = 1'b1;
      tick();
      checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_one_cycle got %b exp 0", timeout_pulse); end
      checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL to_valid_seen got %b exp 0", seen_valid); end
   endtask

   task automatic test_window_edge();
      interval_ready = 1'b0;
      pulse();
      repeat (19998) tick();
      pulse();
      checks++; if (interval !== 16'd19999) begin errors++; $display("FAIL edge_interval got %0d exp 19999", interval); end
      checks++; if (interval_valid !== 1'b1) begin errors++; $display("FAIL edge_valid got %b exp 1", interval_valid); end
      checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL edge_timeout got %b exp 0", timeout_pulse); end
      interval_ready = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_busy_fall got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      interval_ready = 1'b0;
      pulse();
      repeat (9) tick();
      pulse();
      checks++; if (interval !== 16'd10) begin errors++; $display("FAIL hold_interval got %0d exp 10", interval); end
      event_pulse = 1'b1;
      repeat (300) tick();
      event_pulse = 1'b0;
      checks++; if (interval !== 16'd10) begin errors++; $display("FAIL hold_stable got %0d exp 10", interval); end
      checks++; if (interval_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", interval_valid); end
      checks++; if (missed_count !== 8'd255) begin errors++; $display("FAIL hold_missed_sat got %0d exp 255", missed_count); end
      interval_ready = 1'b1;
      pulse();
      interval_ready = 1'b0;
      checks++; if (interval_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_fall got %b exp 0", interval_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
      checks++; if (missed_count !== 8'd255) begin errors++; $display("FAIL b2b_missed got %0d exp 255", missed_count); end
      repeat (6) tick();
      pulse();
      checks++; if (interval !== 16'd7) begin errors++; $display("FAIL b2b_interval got %0d exp 7", interval); end
      interval_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      interval_ready = 1'b1;
      pulse();
      repeat (499) tick();
      rst_n = 1'b0;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      checks++; if (interval !== 16'd0) begin errors++; $display("FAIL rmid_interval got %0d exp 0", interval); end
      checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL rmid_missed got %0d exp 0", missed_count); end
      checks++; if (interval_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", interval_valid); end
      tick();
      rst_n = 1'b1;
      tick();
      pulse();
      repeat (4) tick();
      pulse();
      checks++; if (interval !== 16'd5) begin errors++; $display("FAIL rmid_fresh got %0d exp 5", interval); end
      checks++; if (interval_valid !== 1'b1) begin errors++; $display("FAIL rmid_fresh_valid got %b exp 1", interval_valid); end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_dead_time();
      test_timeout();
      test_window_edge();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
